// File: rtl/top_level_nios2_qsys_0_ocimem_pkg.sv
// Shared definitions for the JTAG on-chip debug memory controller:
// FSM state encoding, jdo field positions and small address helpers.
package top_level_nios2_qsys_0_ocimem_pkg;

  localparam int OCI_ADDR_W     = 8;
  localparam int JDO_ADDR_LSB   = 17;
  localparam int JDO_RD_BIT     = 34;
  localparam int JDO_CLRERR_BIT = 35;
  localparam int JDO_WDATA_LSB  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_JRD,
    ST_JRD_CAP,
    ST_JWR,
    ST_AV_RD,
    ST_AV_RD_DONE,
    ST_AV_WR
  } ocimem_state_e;

  // Index width of a RAM of 'depth' words (at least 1 bit).
  function automatic int ram_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // True when the 8-bit word address maps onto an implemented RAM word.
  function automatic logic addr_hit(input logic [OCI_ADDR_W-1:0] addr, input int depth);
    return int'(addr) < depth;
  endfunction

endpackage

// File: rtl/top_level_nios2_qsys_0_ocimem_ram.sv
// Single-port debug RAM, DEPTH x 32, synchronous read (one-cycle latency),
// byte-enabled write. Contents are not reset.
// Ports: clk; en (access enable); we (write); be (byte enables);
//        addr (word index); wdata; q (read data, valid the cycle after en).
module top_level_nios2_qsys_0_ocimem_ram
  import top_level_nios2_qsys_0_ocimem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = ram_idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      q
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/top_level_nios2_qsys_0_jtag_ocimem_ctrl.sv
// JTAG debug memory controller. Turns take_*_ocimem_* strobes plus jdo into
// reads/writes of a debug RAM shared with an Avalon-MM slave port.
// Ports: clk, reset_n (async, active low); jdo + three JTAG strobes in;
//        MonDReg, monitor_ready, monitor_error back to the debug wrapper;
//        avs_* Avalon-MM slave (waitrequest combinational from state).
//
// state         | meaning
// ST_IDLE       | arbitrate: JTAG write > JTAG read > Avalon write > Avalon read
// ST_JRD        | RAM address driven from MonAReg
// ST_JRD_CAP    | capture RAM data into MonDReg, advance MonAReg
// ST_JWR        | write MonDReg to RAM, advance MonAReg
// ST_AV_RD      | RAM address driven from avs_address
// ST_AV_RD_DONE | avs_readdata valid, waitrequest low
// ST_AV_WR      | byte-enabled write, waitrequest low
module top_level_nios2_qsys_0_jtag_ocimem_ctrl
  import top_level_nios2_qsys_0_ocimem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [37:0]           jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_no_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  output logic [31:0]           MonDReg,
  output logic                  monitor_ready,
  output logic                  monitor_error,
  input  logic [OCI_ADDR_W-1:0] avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [31:0]           avs_writedata,
  input  logic [3:0]            avs_byteenable,
  output logic [31:0]           avs_readdata,
  output logic                  avs_waitrequest
);

  localparam int IDX_W = ram_idx_w(DEPTH);

  ocimem_state_e         state;
  logic [OCI_ADDR_W-1:0] mon_a_reg;
  logic                  jrd_pend, jwr_pend;
  logic                  hit_q;

  logic [OCI_ADDR_W-1:0] ram_addr;
  logic                  ram_hit, ram_en, ram_we;
  logic [3:0]            ram_be;
  logic [31:0]           ram_wdata, ram_q;

  logic jdo_rd, rd_req, a_accept, jrd_drop, jwr_drop, jtag_oor, any_strobe;
  logic unused_jdo_bits;

  assign unused_jdo_bits = ^{jdo[37:36], jdo[2:0]};

  assign jdo_rd     = jdo[JDO_RD_BIT];
  assign rd_req     = take_no_action_ocimem_a | (take_action_ocimem_a & jdo_rd);
  assign jrd_drop   = rd_req & jrd_pend;
  assign jwr_drop   = take_action_ocimem_b & jwr_pend;
  // A read-requesting address strobe is dropped as a whole when a read is already queued.
  assign a_accept   = take_action_ocimem_a & ~(jdo_rd & jrd_pend);
  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

  always_comb begin
    ram_addr        = (state == ST_JRD || state == ST_JWR) ? mon_a_reg : avs_address;
    ram_hit         = addr_hit(ram_addr, DEPTH);
    ram_en          = ram_hit && (state inside {ST_JRD, ST_JWR, ST_AV_RD, ST_AV_WR});
    ram_we          = (state == ST_JWR) || (state == ST_AV_WR);
    ram_be          = (state == ST_AV_WR) ? avs_byteenable : 4'hF;
    ram_wdata       = (state == ST_AV_WR) ? avs_writedata : MonDReg;
    jtag_oor        = (state == ST_JRD || state == ST_JWR) && !ram_hit;
    avs_waitrequest = !(state == ST_AV_WR || state == ST_AV_RD_DONE);
    avs_readdata    = (state == ST_AV_RD_DONE && hit_q) ? ram_q : 32'd0;
  end

  top_level_nios2_qsys_0_ocimem_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr[IDX_W-1:0]),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      mon_a_reg     <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      jrd_pend      <= 1'b0;
      jwr_pend      <= 1'b0;
      hit_q         <= 1'b0;
    end else begin
      // Remembers whether the RAM read issued this cycle was in range.
      hit_q <= ram_hit;

      case (state)
        ST_IDLE: begin
          if (jwr_pend) begin
            state    <= ST_JWR;
            jwr_pend <= 1'b0;
          end else if (jrd_pend) begin
            state    <= ST_JRD;
            jrd_pend <= 1'b0;
          end else if (avs_write) begin
            state <= ST_AV_WR;
          end else if (avs_read) begin
            state <= ST_AV_RD;
          end
        end
        ST_JRD:        state <= ST_JRD_CAP;
        ST_JRD_CAP: begin
          MonDReg       <= hit_q ? ram_q : 32'd0;
          monitor_ready <= 1'b1;
          mon_a_reg     <= mon_a_reg + 8'd1;
          state         <= ST_IDLE;
        end
        ST_JWR: begin
          monitor_ready <= 1'b1;
          mon_a_reg     <= mon_a_reg + 8'd1;
          state         <= ST_IDLE;
        end
        ST_AV_RD:      state <= ST_AV_RD_DONE;
        ST_AV_RD_DONE: state <= ST_IDLE;
        ST_AV_WR:      state <= ST_IDLE;
        default:       state <= ST_IDLE;
      endcase

      // Strobes are handled after the FSM so a new command overrides a completion.
      if (any_strobe) monitor_ready <= 1'b0;
      if (a_accept) begin
        mon_a_reg <= jdo[JDO_ADDR_LSB +: OCI_ADDR_W];
        if (jdo[JDO_CLRERR_BIT]) monitor_error <= 1'b0;
        if (jdo_rd) jrd_pend <= 1'b1;
        else        monitor_ready <= 1'b1;
      end
      if (take_no_action_ocimem_a && !jrd_pend) jrd_pend <= 1'b1;
      if (take_action_ocimem_b && !jwr_pend) begin
        MonDReg  <= jdo[JDO_WDATA_LSB +: 32];
        jwr_pend <= 1'b1;
      end
      if (jtag_oor || jrd_drop || jwr_drop) monitor_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_top_level_nios2_qsys_0_jtag_ocimem_ctrl.sv
module tb_top_level_nios2_qsys_0_jtag_ocimem_ctrl;

  typedef enum int {OP_AW, OP_AR, OP_JA, OP_JN, OP_JB} op_e;

  typedef struct {
    op_e         op;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        rd;
    logic [31:0] exp_d;
    int          exp_c;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_a = 1'b0, take_na = 1'b0, take_b = 1'b0;
  logic [7:0]  avs_address = '0;
  logic        avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  avs_byteenable = '0;

  logic [31:0] mon_d, mon_d64, rdata, rdata64;
  logic        ready, ready64, err, err64, waitreq, waitreq64;

  int nvec = 0;
  int nmis = 0;

  // Reference state: RAM image, JTAG address pointer, monitor data register.
  logic [31:0] m_mem [256];
  logic [7:0]  m_a = '0;
  logic [31:0] m_d = '0;

  vec_t vt [18];

  always #5 clk = ~clk;

  top_level_nios2_qsys_0_jtag_ocimem_ctrl #(.DEPTH(256)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_a), .take_no_action_ocimem_a(take_na),
    .take_action_ocimem_b(take_b),
    .MonDReg(mon_d), .monitor_ready(ready), .monitor_error(err),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(rdata), .avs_waitrequest(waitreq)
  );

  top_level_nios2_qsys_0_jtag_ocimem_ctrl #(.DEPTH(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_a), .take_no_action_ocimem_a(take_na),
    .take_action_ocimem_b(take_b),
    .MonDReg(mon_d64), .monitor_ready(ready64), .monitor_error(err64),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(rdata64), .avs_waitrequest(waitreq64)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Expected values from the behavioural rules; r is the data the op should return.
  task automatic model_step(input op_e op, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic rd, output logic [31:0] r,
                            output int c);
    r = 32'd0;
    c = 0;
    case (op)
      OP_AW: begin
        for (int i = 0; i < 4; i++) if (be[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
        c = 1;
      end
      OP_AR: begin r = m_mem[a]; c = 2; end
      OP_JA: begin
        m_a = a;
        if (rd) begin m_d = m_mem[m_a]; m_a = m_a + 8'd1; c = 4; end
        else c = 1;
        r = m_d;
      end
      OP_JN: begin m_d = m_mem[m_a]; m_a = m_a + 8'd1; r = m_d; c = 4; end
      default: begin m_mem[m_a] = d; m_a = m_a + 8'd1; m_d = d; r = d; c = 3; end
    endcase
  endtask

  task automatic do_op(input op_e op, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic rd, input logic clr,
                       output logic [31:0] got, output logic [31:0] got64, output int cyc);
    cyc = 0;
    @(posedge clk); #1;
    if (op == OP_AW || op == OP_AR) begin
      avs_address = a; avs_writedata = d; avs_byteenable = be;
      avs_write = (op == OP_AW); avs_read = (op == OP_AR);
      while (waitreq && cyc < 20) begin @(posedge clk); #1; cyc++; end
      got = rdata; got64 = rdata64;
      @(posedge clk); #1;
      avs_write = 1'b0; avs_read = 1'b0;
    end else begin
      jdo = '0;
      case (op)
        OP_JA: begin jdo[24:17] = a; jdo[34] = rd; jdo[35] = clr; take_a = 1'b1; end
        OP_JN: take_na = 1'b1;
        default: begin jdo[34:3] = d; take_b = 1'b1; end
      endcase
      @(posedge clk); #1;
      take_a = 1'b0; take_na = 1'b0; take_b = 1'b0;
      cyc = 1;
      while (!ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
      got = mon_d; got64 = mon_d64;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_d, got, got64, d;
    logic [7:0]  a;
    logic [3:0]  be;
    logic        rd;
    op_e         op;
    int          exp_c, cyc, c;

    vt[0]  = '{OP_AW, 8'h10, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0,        1};
    vt[1]  = '{OP_AW, 8'h11, 32'h12345678, 4'hF, 1'b0, 32'h0,        1};
    vt[2]  = '{OP_JA, 8'h10, 32'h0,        4'h0, 1'b1, 32'hCAFEF00D, 4};
    vt[3]  = '{OP_JN, 8'h00, 32'h0,        4'h0, 1'b0, 32'h12345678, 4};
    vt[4]  = '{OP_AW, 8'h20, 32'h00000000, 4'hF, 1'b0, 32'h0,        1};
    vt[5]  = '{OP_AW, 8'h20, 32'hAABBCCDD, 4'h5, 1'b0, 32'h0,        1};
    vt[6]  = '{OP_AR, 8'h20, 32'h0,        4'h0, 1'b0, 32'h00BB00DD, 2};
    vt[7]  = '{OP_AW, 8'h21, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0,        1};
    vt[8]  = '{OP_AW, 8'h21, 32'h00000000, 4'hA, 1'b0, 32'h0,        1};
    vt[9]  = '{OP_AR, 8'h21, 32'h0,        4'h0, 1'b0, 32'h00FF00FF, 2};
    vt[10] = '{OP_JA, 8'hFE, 32'h0,        4'h0, 1'b0, 32'h12345678, 1};
    vt[11] = '{OP_JB, 8'h00, 32'h1,        4'h0, 1'b0, 32'h1,        3};
    vt[12] = '{OP_JB, 8'h00, 32'h2,        4'h0, 1'b0, 32'h2,        3};
    vt[13] = '{OP_JB, 8'h00, 32'h3,        4'h0, 1'b0, 32'h3,        3};
    vt[14] = '{OP_AR, 8'hFE, 32'h0,        4'h0, 1'b0, 32'h1,        2};
    vt[15] = '{OP_AR, 8'hFF, 32'h0,        4'h0, 1'b0, 32'h2,        2};
    vt[16] = '{OP_AR, 8'h00, 32'h0,        4'h0, 1'b0, 32'h3,        2};
    vt[17] = '{OP_JA, 8'h00, 32'h0,        4'h0, 1'b1, 32'h3,        4};

    // Reset values
    #12;
    chk("rst_mondreg", mon_d, 32'h0);
    chk("rst_ready", {31'd0, ready}, 32'h0);
    chk("rst_error", {31'd0, err}, 32'h0);
    chk("rst_readdata", rdata, 32'h0);
    chk("rst_waitreq", {31'd0, waitreq}, 32'h1);
    @(posedge clk); #1 reset_n = 1'b1;

    // Preload every word so the reference image is fully known.
    for (int i = 0; i < 256; i++) begin
      a = 8'(i); d = $urandom;
      model_step(OP_AW, a, d, 4'hF, 1'b0, exp_d, exp_c);
      do_op(OP_AW, a, d, 4'hF, 1'b0, 1'b0, got, got64, cyc);
      chk("preload_cycles", 32'(cyc), 32'(exp_c));
    end

    // Directed table
    for (int i = 0; i < 18; i++) begin
      model_step(vt[i].op, vt[i].a, vt[i].d, vt[i].be, vt[i].rd, exp_d, exp_c);
      do_op(vt[i].op, vt[i].a, vt[i].d, vt[i].be, vt[i].rd, 1'b0, got, got64, cyc);
      chk($sformatf("vec%0d_data", i), got, vt[i].exp_d);
      chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vt[i].exp_c));
    end
    chk("table_error", {31'd0, err}, 32'h0);

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      op = op_e'($urandom_range(0, 4));
      a = 8'($urandom); d = $urandom; be = 4'($urandom); rd = 1'($urandom_range(0, 1));
      model_step(op, a, d, be, rd, exp_d, exp_c);
      do_op(op, a, d, be, rd, 1'b0, got, got64, cyc);
      chk($sformatf("rnd%0d_op%0d_data", i, op), got, exp_d);
      chk($sformatf("rnd%0d_op%0d_cycles", i, op), 32'(cyc), 32'(exp_c));
    end
    chk("rnd_error", {31'd0, err}, 32'h0);

    // Contention: JTAG write pending in IDLE while an Avalon read to the same word arrives
    model_step(OP_JA, 8'h30, 32'h0, 4'h0, 1'b0, exp_d, exp_c);
    do_op(OP_JA, 8'h30, 32'h0, 4'h0, 1'b0, 1'b0, got, got64, cyc);
    model_step(OP_JB, 8'h00, 32'h5A5A1234, 4'h0, 1'b0, exp_d, exp_c);
    @(posedge clk); #1;
    jdo = '0; jdo[34:3] = 32'h5A5A1234; take_b = 1'b1;
    @(posedge clk); #1;
    take_b = 1'b0; avs_address = 8'h30; avs_read = 1'b1;
    c = 0;
    while (waitreq && c < 20) begin @(posedge clk); #1; c++; end
    // Uncontended read completes after 2 cycles; the JWR state and the return to IDLE add 2.
    chk("contend_cycles", 32'(c), 32'd4);
    chk("contend_data", rdata, 32'h5A5A1234);
    chk("contend_ready", {31'd0, ready}, 32'h1);
    @(posedge clk); #1 avs_read = 1'b0;
    do_op(OP_AR, 8'h30, 32'h0, 4'h0, 1'b0, 1'b0, got, got64, cyc);
    chk("contend_readback", got, exp_d);

    // Out of range on the 64-word instance
    model_step(OP_JA, 8'h40, 32'h0, 4'h0, 1'b1, exp_d, exp_c);
    do_op(OP_JA, 8'h40, 32'h0, 4'h0, 1'b1, 1'b0, got, got64, cyc);
    chk("oor_jrd_cycles", 32'(cyc), 32'd4);
    chk("oor_jrd_data64", got64, 32'h0);
    chk("oor_jrd_err64", {31'd0, err64}, 32'h1);
    chk("oor_jrd_data256", got, exp_d);
    chk("oor_jrd_err256", {31'd0, err}, 32'h0);
    model_step(OP_JA, 8'h00, 32'h0, 4'h0, 1'b0, exp_d, exp_c);
    do_op(OP_JA, 8'h00, 32'h0, 4'h0, 1'b0, 1'b1, got, got64, cyc);
    chk("clrerr_err64", {31'd0, err64}, 32'h0);
    model_step(OP_AW, 8'h41, 32'hDEADBEEF, 4'hF, 1'b0, exp_d, exp_c);
    do_op(OP_AW, 8'h41, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, got, got64, cyc);
    model_step(OP_AR, 8'h41, 32'h0, 4'h0, 1'b0, exp_d, exp_c);
    do_op(OP_AR, 8'h41, 32'h0, 4'h0, 1'b0, 1'b0, got, got64, cyc);
    chk("oor_avrd_data64", got64, 32'h0);
    chk("oor_avrd_cycles", 32'(cyc), 32'd2);
    chk("oor_av_err64", {31'd0, err64}, 32'h0);
    model_step(OP_AR, 8'h01, 32'h0, 4'h0, 1'b0, exp_d, exp_c);
    do_op(OP_AR, 8'h01, 32'h0, 4'h0, 1'b0, 1'b0, got, got64, cyc);
    chk("oor_no_alias64", got64, exp_d);

    // Overrun: two streaming-read strobes back to back; the second is dropped
    model_step(OP_JN, 8'h00, 32'h0, 4'h0, 1'b0, exp_d, exp_c);
    @(posedge clk); #1 take_na = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 take_na = 1'b0;
    c = 0;
    while (!ready && c < 20) begin @(posedge clk); #1; c++; end
    chk("overrun_done", {31'd0, ready}, 32'h1);
    chk("overrun_err", {31'd0, err}, 32'h1);
    chk("overrun_data", mon_d, exp_d);
    model_step(OP_JN, 8'h00, 32'h0, 4'h0, 1'b0, exp_d, exp_c);
    do_op(OP_JN, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0, got, got64, cyc);
    chk("overrun_single_read", got, exp_d);
    model_step(OP_JA, 8'h05, 32'h0, 4'h0, 1'b0, exp_d, exp_c);
    do_op(OP_JA, 8'h05, 32'h0, 4'h0, 1'b0, 1'b1, got, got64, cyc);
    chk("clrerr_err", {31'd0, err}, 32'h0);

    // Reset asserted while in JRD
    model_step(OP_AW, 8'h10, 32'hCAFEF00D, 4'hF, 1'b0, exp_d, exp_c);
    do_op(OP_AW, 8'h10, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, got, got64, cyc);
    model_step(OP_JA, 8'h10, 32'h0, 4'h0, 1'b1, exp_d, exp_c);
    do_op(OP_JA, 8'h10, 32'h0, 4'h0, 1'b1, 1'b0, got, got64, cyc);
    chk("prereset_data", got, 32'hCAFEF00D);
    @(posedge clk); #1;
    jdo = '0; jdo[24:17] = 8'h12; jdo[34] = 1'b1; take_a = 1'b1;
    @(posedge clk); #1 take_a = 1'b0;
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    chk("midrst_mondreg", mon_d, 32'h0);
    chk("midrst_ready", {31'd0, ready}, 32'h0);
    chk("midrst_error", {31'd0, err}, 32'h0);
    chk("midrst_readdata", rdata, 32'h0);
    chk("midrst_waitreq", {31'd0, waitreq}, 32'h1);
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    m_a = 8'h00; m_d = 32'h0;
    model_step(OP_JN, 8'h00, 32'h0, 4'h0, 1'b0, exp_d, exp_c);
    do_op(OP_JN, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0, got, got64, cyc);
    chk("postrst_read_data", got, exp_d);
    chk("postrst_read_cycles", 32'(cyc), 32'd4);
    model_step(OP_AR, 8'h12, 32'h0, 4'h0, 1'b0, exp_d, exp_c);
    do_op(OP_AR, 8'h12, 32'h0, 4'h0, 1'b0, 1'b0, got, got64, cyc);
    chk("postrst_avrd_data", got, exp_d);
    chk("postrst_avrd_cycles", 32'(cyc), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
